cvp_vlsu: RTL

- Parametrised vector load/store unit: moves one vector register between system memory and the vector register file as a strided sequence of element transfers.
- Successor to the fixed 16-element, unit-stride VLD/VST sequencing in the CVP14 control FSM. Adds configurable data/address width, vector length, per-operation length, signed stride, a memory wait-state handshake and an address-wrap flag.
- Sits between the core control FSM (Start/Done) and the shared memory port.

---
 rtl/cvp_vlsu.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cvp_vlsu.sv
// Vector load/store sequencer: walks one vector register through memory as a strided series
// of element transfers with a MemRdy wait-state handshake and a sticky address-wrap flag.
module cvp_vlsu #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned VLEN   = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Op,
  input  logic [ADDR_W-1:0] Base,
  input  logic [ADDR_W-1:0] Stride,
  input  logic [IDX_W-1:0]  Len,
  output logic [ADDR_W-1:0] Addr,
  output logic              RD,
  output logic              WR,
  output logic [DATA_W-1:0] DataOut,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              MemRdy,
  output logic [IDX_W-1:0]  vIdx,
  input  logic [DATA_W-1:0] vRdData,
  output logic              vWrEn,
  output logic [DATA_W-1:0] vWrData,
  output logic              Busy,
  output logic              Done,
  output logic              Wrap
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLdReq = 3'd1;
  localparam logic [2:0] StLdWb  = 3'd2;
  localparam logic [2:0] StStRd  = 3'd3;
  localparam logic [2:0] StStReq = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [IDX_W-1:0] LastMax = IDX_W'(VLEN - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wren_q, wren_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;

  // Unsigned add with one extra bit; for a negative stride a missing carry means a borrow.
  logic [ADDR_W:0] addr_sum;
  logic            wrap_step;
  assign addr_sum  = {1'b0, addr_q} + {1'b0, stride_q};
  assign wrap_step = stride_q[ADDR_W-1] ? ~addr_sum[ADDR_W] : addr_sum[ADDR_W];

  always_comb begin
    state_d  = state_q;
    stride_d = stride_q;
    last_d   = last_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    dout_d   = dout_q;
    idx_d    = idx_q;
    wren_d   = 1'b0;
    wrdata_d = wrdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wrap_d   = wrap_q;

    case (state_q)
      StIdle: begin
        if (Start) begin
          stride_d = Stride;
          last_d   = (Len == '0) ? LastMax : Len - IDX_W'(1);
          addr_d   = Base;
          idx_d    = '0;
          busy_d   = 1'b1;
          wrap_d   = 1'b0;
          if (Op) begin
            state_d = StStRd;
          end else begin
            state_d = StLdReq;
            rd_d    = 1'b1;
          end
        end
      end
      StLdReq: begin
        if (MemRdy) begin
          wrdata_d = DataIn;
          rd_d     = 1'b0;
          wren_d   = 1'b1;
          state_d  = StLdWb;
        end
      end
      StLdWb: begin
        if (idx_q == last_q) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          addr_d  = addr_sum[ADDR_W-1:0];
          wrap_d  = wrap_q | wrap_step;
          rd_d    = 1'b1;
          state_d = StLdReq;
        end
      end
      StStRd: begin
        dout_d  = vRdData;
        wr_d    = 1'b1;
        state_d = StStReq;
      end
      StStReq: begin
        if (MemRdy) begin
          wr_d = 1'b0;
          if (idx_q == last_q) begin
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            addr_d  = addr_sum[ADDR_W-1:0];
            wrap_d  = wrap_q | wrap_step;
            state_d = StStRd;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q  <= StIdle;
      stride_q <= '0;
      last_q   <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      dout_q   <= '0;
      idx_q    <= '0;
      wren_q   <= 1'b0;
      wrdata_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stride_q <= stride_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      dout_q   <= dout_d;
      idx_q    <= idx_d;
      wren_q   <= wren_d;
      wrdata_q <= wrdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
    end
  end

  assign Addr    = addr_q;
  assign RD      = rd_q;
  assign WR      = wr_q;
  assign DataOut = dout_q;
  assign vIdx    = idx_q;
  assign vWrEn   = wren_q;
  assign vWrData = wrdata_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Wrap    = wrap_q;

endmodule
